// File: rtl/div_iter.sv
// div_iter: iterative restoring divider, one quotient bit per cycle, signed/unsigned, with E-stage stall.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, ZERO, BUSY, DONE} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [WIDTH:0]     trial, diff;
  logic [WIDTH-1:0]   q_step, r_step, q_fin, r_fin;
  logic               accept, last;
  assign accept = state_q == IDLE && start_i && !annul_i;
  assign last   = cnt_q == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  always_comb begin
    state_d = IDLE;
    if (!annul_i)
      case (state_q)
        IDLE:    state_d = !start_i ? IDLE : (opdata2_i == '0 ? ZERO : BUSY);
        BUSY:    state_d = last ? DONE : BUSY;
        ZERO:    state_d = DONE;
        default: state_d = IDLE;
      endcase
  end
  always_comb begin
    ready_o = state_q == DONE && !annul_i;
    stall_o = resetn && !annul_i && ((state_q == IDLE && start_i) || state_q == ZERO || state_q == BUSY);
  end
  // trial is the WIDTH+1-bit partial remainder; its sign after subtracting decides restore vs keep
  always_comb begin
    trial  = {rem_q, quo_q[WIDTH-1]};
    diff   = trial - {1'b0, dvs_q};
    r_step = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    q_step = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    q_fin  = qneg_q ? -q_step : q_step;
    r_fin  = rneg_q ? -r_step : r_step;
    cnt_d  = accept ? '0 : (state_q == BUSY ? CW'(cnt_q + 1'b1) : cnt_q);
    rem_d  = accept ? '0 : (state_q == BUSY ? r_step : rem_q);
    quo_d  = accept ? (signed_i && opdata1_i[WIDTH-1] ? -opdata1_i : opdata1_i)
                    : (state_q == BUSY ? q_step : quo_q);
    dvs_d  = accept ? (signed_i && opdata2_i[WIDTH-1] ? -opdata2_i : opdata2_i) : dvs_q;
    qneg_d = accept ? signed_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]) : qneg_q;
    rneg_d = accept ? signed_i && opdata1_i[WIDTH-1] : rneg_q;
    res_d  = annul_i ? res_q
           : state_q == ZERO ? '0
           : state_q == BUSY && last ? {r_fin, q_fin} : res_q;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      res_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      res_q  <= res_d;
    end
  assign result_o = res_q;
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: randomized and directed checks of div_iter against an arithmetic reference model.
module tb_div_iter;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start_i = 1'b0, signed_i = 1'b0, annul_i = 1'b0;
  logic [31:0] opdata1_i = '0, opdata2_i = '0;
  logic [63:0] result_o;
  logic        ready_o, stall_o;
  int          n_chk = 0, n_pass = 0;
  logic [63:0] prev;
  logic        rdy_seen;

  div_iter #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .signed_i(signed_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 0) return 64'd0;
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  // accept in cycle 0; optionally hold start_i; scramble operands while the divide runs
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b, input logic hold);
    int          exp_lat, got;
    logic [63:0] smask, exp_res;
    exp_lat = (b == 0) ? 2 : 33;
    exp_res = ref_div(s, a, b);
    got = -1;
    smask = '0;
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = s; opdata1_i = a; opdata2_i = b; annul_i = 1'b0;
    for (int c = 0; c <= 40 && got < 0; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        start_i = hold; signed_i = 1'($urandom); opdata1_i = $urandom; opdata2_i = $urandom;
      end
      @(negedge clk);
      smask |= 64'(stall_o) << c;
      if (ready_o) got = c;
    end
    chk("latency", 64'(got), 64'(exp_lat));
    chk("stall_window", smask, (64'd1 << exp_lat) - 64'd1);
    chk("result", result_o, exp_res);
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    chk("ready_pulse", 64'(ready_o), 64'd0);
    chk("result_hold", result_o, exp_res);
  endtask

  initial begin
    start_i = 1'b1;
    #2;
    chk("rst_result", result_o, 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    run_div(1'b0, 32'd55, 32'd0, 1'b0);
    run_div(1'b1, 32'hFFFF_FFF0, 32'd0, 1'b0);
    run_div(1'b0, 32'd100, 32'd7, 1'b1);
    chk("u100_7", result_o, {32'd2, 32'd14});
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("s_m7_2", result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("s_ovf", result_o, {32'h0, 32'h8000_0000});

    prev = result_o;
    rdy_seen = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      @(negedge clk);
      rdy_seen |= ready_o;
    end
    @(posedge clk); #1;
    annul_i = 1'b1;
    @(negedge clk);
    chk("annul_stall", 64'(stall_o), 64'd0);
    rdy_seen |= ready_o;
    @(posedge clk); #1;
    annul_i = 1'b0;
    @(negedge clk);
    chk("annul_ready", 64'(rdy_seen | ready_o), 64'd0);
    chk("annul_result", result_o, prev);
    run_div(1'b0, 32'd500, 32'd9, 1'b0);

    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd12345; opdata2_i = 32'd7;
    for (int c = 1; c <= 5; c++) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("arst_result", result_o, 64'd0);
    chk("arst_ready", 64'(ready_o), 64'd0);
    chk("arst_stall", 64'(stall_o), 64'd0);
    #3 resetn = 1'b1;
    start_i = 1'b0;
    rdy_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      rdy_seen |= ready_o;
    end
    chk("arst_no_ready", 64'(rdy_seen), 64'd0);

    for (int i = 0; i < 40; i++) begin
      logic        s;
      logic [31:0] a, b;
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = -32'($urandom_range(1, 15));
        3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: b = $urandom;
      endcase
      run_div(s, a, b, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter WIDTH, default 32, SHALL set the operand width in bits.
REQ-003 Port clk, input, 1, SHALL be the rising-edge clock.
REQ-004 Port resetn, input, 1, SHALL be the asynchronous active-low reset.
REQ-005 Port start_i, input, 1, SHALL mark a divide instruction valid in the E stage.
REQ-006 Port signed_i, input, 1, SHALL select signed (1) or unsigned (0) division; it is sampled on accept.
REQ-007 Port opdata1_i, input, WIDTH, SHALL carry the dividend; it is sampled on accept.
REQ-008 Port opdata2_i, input, WIDTH, SHALL carry the divisor; it is sampled on accept.
REQ-009 Port annul_i, input, 1, SHALL cancel the operation (pipeline flush).
REQ-010 Port result_o, output, 2*WIDTH, SHALL carry {remainder (HI), quotient (LO)}.
REQ-011 Port ready_o, output, 1, SHALL pulse for one cycle when result_o is valid.
REQ-012 Port stall_o, output, 1, SHALL drive the hazard unit's E-stage divide stall input.

Function
REQ-013 The state machine SHALL have the states IDLE, ZERO, BUSY and DONE.
REQ-014 Accept SHALL occur when state=IDLE, start_i=1 and annul_i=0.
REQ-015 On accept, the operands and signed_i SHALL be latched into internal registers.
REQ-016 On accept with divisor=0, the next state SHALL be ZERO; otherwise it SHALL be BUSY, with the step counter cleared to 0.
REQ-017 On accept in signed mode, the absolute values of both operands SHALL be latched, together with the dividend sign and the quotient sign (dividend sign XOR divisor sign).
REQ-018 Each BUSY cycle SHALL perform one restoring shift-subtract step: one quotient bit per cycle, MSB first, with a WIDTH+1-bit partial remainder.
REQ-019 BUSY SHALL last exactly WIDTH cycles and then go to DONE.
REQ-020 On the BUSY->DONE edge, result_o SHALL be loaded as follows.
- Quotient: negated (two's complement) if signed and the signs differ.
- Remainder: negated if signed and the dividend is negative.
REQ-021 ZERO SHALL last one cycle, load result_o=0, and go to DONE.
REQ-022 DONE SHALL assert ready_o=1 for that cycle only and go to IDLE unconditionally.
REQ-023 Back-to-back divides SHALL be accepted from IDLE in the cycle after DONE.
REQ-024 result_o SHALL hold its value from the DONE load until the next DONE load.
REQ-025 Latency SHALL be as follows, with accept in cycle 0.
- Nonzero divisor: BUSY in cycles 1..WIDTH, DONE/ready_o in cycle WIDTH+1.
- Zero divisor: ZERO in cycle 1, DONE in cycle 2.
REQ-026 stall_o SHALL be combinational: 1 when annul_i=0 and either (state=IDLE and start_i=1) or state is ZERO or BUSY; 0 otherwise, including DONE.
REQ-027 For a nonzero divisor, stall_o SHALL be high for WIDTH+1 consecutive cycles (cycles 0..WIDTH).
REQ-028 annul_i=1 in any state SHALL force the next state to IDLE.
REQ-029 annul_i=1 SHALL suppress that operation's ready_o and leave result_o unchanged.
REQ-030 annul_i=1 SHALL take precedence over start_i in the same cycle.
REQ-031 Changes on start_i or the operand inputs during ZERO or BUSY SHALL be ignored.
REQ-032 A signed most-negative / -1 divide SHALL wrap: quotient = most-negative value, remainder = 0, with no exception.
REQ-033 Unsigned mode SHALL treat the operands as 0..2^WIDTH-1 with no sign correction.

Reset
REQ-034 resetn=0 SHALL immediately, without waiting for a clock edge, set state=IDLE, counter=0, result_o=0 and ready_o=0.
REQ-035 stall_o SHALL read 0 during reset.
REQ-036 A reset during BUSY or ZERO SHALL abort the operation with no ready_o pulse.
REQ-037 After resetn rises, the first accept SHALL be possible on the first clock edge.

Verification
REQ-038 Unsigned 100/7 with start_i held until ready SHALL give result_o={32'd2, 32'd14}, ready_o in cycle 33 and stall_o high in cycles 0..32.
REQ-039 Signed -7/2 (0xFFFFFFF9/0x2) SHALL give quotient 0xFFFFFFFD and remainder 0xFFFFFFFF.
REQ-040 Signed 0x80000000/0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0x00000000.
REQ-041 Divisor 0 (any mode) SHALL give result_o=0, ready_o in cycle 2, and stall_o high in cycles 0..1 only.
REQ-042 annul_i pulsed in cycle 10 of a divide SHALL return the block to IDLE in cycle 11 with no ready_o and result_o unchanged; a new start in cycle 12 SHALL complete normally in cycle 45.
REQ-043 resetn dropped asynchronously in cycle 5 SHALL zero result_o and ready_o, drop stall_o immediately, and leave no ready_o after release.
